// File: rtl/mc_pkg.sv
// Shared definitions for the path feeder: sample/depth parameters and FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package mc_pkg;

    localparam int PATH_W      = 12;
    localparam int DATA_LENGTH = 256;
    localparam int DAY         = 8;
    localparam int ADDR_W      = 11;
    localparam int DAY_W       = 3;
    localparam int DEPTH       = DATA_LENGTH * DAY;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } feed_state_t;

endpackage

// File: rtl/path_feeder_if.sv
// Bundle of load, control and sample-stream signals between MC_CORE and the feeder.
// Latency: none (wiring only).
// Backpressure: none; MC_CORE paces passes with the resend pulse.
// master = MC_CORE/loader side, slave = path_feeder side.
interface path_feeder_if;
    import mc_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PATH_W-1:0] wr_data;
    logic              start;
    logic              resend;
    logic [PATH_W-1:0] path;
    logic              path_valid;
    logic [DAY_W-1:0]  day_idx;
    logic              pass;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start, resend,
        input  path, path_valid, day_idx, pass, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, resend,
        output path, path_valid, day_idx, pass, done
    );

endinterface

// File: rtl/path_ram.sv
// Path sample memory: one write port, one synchronous read port with registered output.
// Latency: read data valid one cycle after rd_en/rd_addr; output holds when rd_en=0.
// Backpressure: none; reset clears only the output register, never the array.
// Ports: clk, rst, wr_en/wr_addr/wr_data (load), rd_en/rd_addr (read), rd_data (registered).
module path_ram #(
    parameter int WIDTH = mc_pkg::PATH_W,
    parameter int DEPTH = mc_pkg::DEPTH,
    parameter int AW    = mc_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    import mc_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/path_feeder.sv
// Streams one day of path samples per pass to MC_CORE, two passes per day, over DAY days.
// Latency: first sample two cycles after start; each stream one sample per cycle.
// Backpressure: none within a stream; resend (in STREAM or WAIT) advances to the next pass.
// Ports: clk, rst (sync, active-high), bus (slave modport: load, start/resend, path stream, done).
module path_feeder #(
    parameter int PATH_W      = mc_pkg::PATH_W,
    parameter int DATA_LENGTH = mc_pkg::DATA_LENGTH,
    parameter int DAY         = mc_pkg::DAY
) (
    input  logic          clk,
    input  logic          rst,
    path_feeder_if.slave  bus
);
    import mc_pkg::*;

    localparam int IDX_W = $clog2(DATA_LENGTH);
    localparam int DW    = $clog2(DAY);

    feed_state_t       state_q, state_d;
    logic [DW-1:0]     day_q, day_d;
    logic              pass_q, pass_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              valid_q;
    logic              issue;
    logic [ADDR_W-1:0] rd_addr;

    // day*DATA_LENGTH + idx never exceeds DEPTH-1 because idx stops at DATA_LENGTH-1.
    assign rd_addr = ADDR_W'(day_q) * ADDR_W'(DATA_LENGTH) + ADDR_W'(idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            day_q   <= '0;
            pass_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            day_q   <= day_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            valid_q <= issue;
        end
    end

    always_comb begin
        state_d = state_q;
        day_d   = day_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                    day_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            STREAM, WAIT: begin
                if (bus.resend) begin
                    // No read is issued this cycle, which yields exactly one
                    // invalid cycle before the next stream's first sample.
                    idx_d = '0;
                    if (!pass_q) begin
                        pass_d  = 1'b1;
                        state_d = STREAM;
                    end else if (day_q != DW'(DAY - 1)) begin
                        day_d   = day_q + DW'(1);
                        pass_d  = 1'b0;
                        state_d = STREAM;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (state_q == STREAM) begin
                    issue = 1'b1;
                    if (idx_q == IDX_W'(DATA_LENGTH - 1)) begin
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    path_ram #(
        .WIDTH (PATH_W),
        .DEPTH (DATA_LENGTH * DAY),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en && (state_q == IDLE)),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (bus.path)
    );

    assign bus.path_valid = valid_q;
    assign bus.day_idx    = day_q;
    assign bus.pass       = pass_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_path_feeder.sv
// Bench for path_feeder: scoreboard of expected samples, scenario tasks with inline checks.
module tb_path_feeder;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    path_feeder_if bus();

    path_feeder #(
        .PATH_W      (PATH_W),
        .DATA_LENGTH (DATA_LENGTH),
        .DAY         (DAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [PATH_W-1:0] data;
        logic [DAY_W-1:0]  day;
        logic              pass;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_stream(input int first, input int n, input int day, input bit pass);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = PATH_W'(day * DATA_LENGTH + first + i);
            e.day  = DAY_W'(day);
            e.pass = pass;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_resend();
        bus.resend = 1'b1;
        @(negedge clk);
        bus.resend = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.path_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.path_valid); end
        checks++; if (bus.path !== '0) begin errors++; $display("FAIL reset_path got %h expected 000", bus.path); end
        checks++; if (bus.day_idx !== '0) begin errors++; $display("FAIL reset_day got %0d expected 0", bus.day_idx); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b expected 0", bus.pass); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_memory();
        for (int a = 0; a < DEPTH; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'(a);
            bus.wr_data = PATH_W'(a);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_stream();
        bit ok;
        push_stream(0, DATA_LENGTH, 0, 1'b0);
        pulse_start();
        checks++; if (bus.path_valid !== 1'b0) begin errors++; $display("FAIL first_lat_c1 valid got %b expected 0", bus.path_valid); end
        @(negedge clk);
        checks++; if (bus.path_valid !== 1'b1 || bus.path !== 12'h000) begin errors++; $display("FAIL first_lat_c2 valid/path got %b/%h expected 1/000", bus.path_valid, bus.path); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_drain got %0d left expected 0", sb.size()); end
        @(negedge clk);
        checks++; if (bus.path_valid !== 1'b0 || bus.path !== 12'h0FF) begin errors++; $display("FAIL first_end_hold valid/path got %b/%h expected 0/0ff", bus.path_valid, bus.path); end
    endtask

    task automatic test_replay_and_next_day();
        bit ok;
        push_stream(0, DATA_LENGTH, 0, 1'b1);
        pulse_resend();
        checks++; if (bus.path_valid !== 1'b0) begin errors++; $display("FAIL replay_gap got %b expected 0", bus.path_valid); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL replay_drain got %0d left expected 0", sb.size()); end
        push_stream(0, DATA_LENGTH, 1, 1'b0);
        pulse_resend();
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL day1_drain got %0d left expected 0", sb.size()); end
        @(negedge clk);
        checks++; if (bus.path !== 12'h1FF || bus.day_idx !== 3'd1) begin errors++; $display("FAIL day1_end path/day got %h/%0d expected 1ff/1", bus.path, bus.day_idx); end
    endtask

    task automatic test_full_run();
        bit ok;
        int bad;
        for (int s = 3; s < 2 * DAY; s++) begin
            push_stream(0, DATA_LENGTH, s / 2, 1'(s % 2));
            pulse_resend();
            wait_drain(ok);
            checks++; if (!ok) begin errors++; $display("FAIL run_stream_%0d_drain got %0d left expected 0", s, sb.size()); end
        end
        @(negedge clk);
        checks++; if (bus.path !== 12'h7FF || bus.day_idx !== 3'd7 || bus.pass !== 1'b1) begin errors++; $display("FAIL last_stream path/day/pass got %h/%0d/%b expected 7ff/7/1", bus.path, bus.day_idx, bus.pass); end
        pulse_resend();
        checks++; if (bus.done !== 1'b1 || bus.path_valid !== 1'b0) begin errors++; $display("FAIL done_pulse done/valid got %b/%b expected 1/0", bus.done, bus.path_valid); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got %b expected 0", bus.done); end
        pulse_resend();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.path_valid !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_resend_ignored got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_resend_mid_stream();
        bit ok;
        bit found;
        push_stream(0, 101, 0, 1'b0);
        push_stream(0, DATA_LENGTH, 0, 1'b1);
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.path_valid === 1'b1 && bus.path === 12'd100) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_find_sample100 got timeout expected sample 100"); end
        if (found) begin
            pulse_resend();
            checks++; if (bus.path_valid !== 1'b0 || bus.path !== 12'd100) begin errors++; $display("FAIL mid_bubble valid/path got %b/%h expected 0/064", bus.path_valid, bus.path); end
            @(negedge clk);
            checks++; if (bus.path_valid !== 1'b1 || bus.path !== 12'h000 || bus.pass !== 1'b1) begin errors++; $display("FAIL mid_restart valid/path/pass got %b/%h/%b expected 1/000/1", bus.path_valid, bus.path, bus.pass); end
        end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain got %0d left expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit found;
        int bad;
        for (int s = 2; s < 6; s++) begin
            push_stream(0, DATA_LENGTH, s / 2, 1'(s % 2));
            pulse_resend();
            wait_drain(ok);
            checks++; if (!ok) begin errors++; $display("FAIL pre_rst_stream_%0d_drain got %0d left expected 0", s, sb.size()); end
        end
        push_stream(0, 51, 3, 1'b0);
        pulse_resend();
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.path_valid === 1'b1 && bus.path === 12'h332) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_find_sample50 got timeout expected sample 332"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.path_valid !== 1'b0 || bus.day_idx !== 3'd0 || bus.pass !== 1'b0 || bus.path !== '0) begin errors++; $display("FAIL rst_abort valid/day/pass/path got %b/%0d/%b/%h expected 0/0/0/000", bus.path_valid, bus.day_idx, bus.pass, bus.path); end
        sb.delete();
        pulse_resend();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.path_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_idle got %0d valid cycles expected 0", bad); end
        push_stream(0, DATA_LENGTH, 0, 1'b0);
        pulse_start();
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_restart_drain got %0d left expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_write_ignored();
        bit ok;
        int bad;
        pulse_start();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.path_valid !== 1'b0 || bus.day_idx !== 3'd0 || bus.pass !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_start_ignored got %0d bad cycles expected 0", bad); end
        push_stream(0, DATA_LENGTH, 0, 1'b1);
        pulse_resend();
        repeat (20) @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 11'h005;
        bus.wr_data = 12'hFFF;
        repeat (10) @(negedge clk);
        bus.wr_en = 1'b0;
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_stream_drain got %0d left expected 0", sb.size()); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_stream(0, DATA_LENGTH, 0, 1'b0);
        pulse_start();
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_replay_drain got %0d left expected 0", sb.size()); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.resend  = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (bus.path_valid === 1'b1) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL sample_extra got %h day %0d pass %b expected no sample", bus.path, bus.day_idx, bus.pass);
                        end else begin
                            e = sb.pop_front();
                            if (bus.path !== e.data || bus.day_idx !== e.day || bus.pass !== e.pass) begin
                                errors++;
                                $display("FAIL sample got %h/%0d/%b expected %h/%0d/%b", bus.path, bus.day_idx, bus.pass, e.data, e.day, e.pass);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        load_memory();
        test_first_stream();
        test_replay_and_next_day();
        test_full_run();
        test_resend_mid_stream();
        test_reset_mid_stream();
        test_write_ignored();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
